// File: rtl/game_board_ctrl_pkg.sv
// Shared encodings for the tic-tac-toe board controller: cell, result and
// move-error codes, FSM states, and board access helpers.
package game_board_ctrl_pkg;

  localparam int unsigned CELL_COUNT = 9;

  localparam logic [1:0] CELL_P1    = 2'd0;
  localparam logic [1:0] CELL_P2    = 2'd1;
  localparam logic [1:0] CELL_EMPTY = 2'd2;

  localparam logic [2:0] RES_P1   = 3'd0;
  localparam logic [2:0] RES_P2   = 3'd1;
  localparam logic [2:0] RES_DRAW = 3'd2;
  localparam logic [2:0] RES_NONE = 3'd3;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_OCCUPIED = 2'd1;
  localparam logic [1:0] ERR_TURN     = 2'd2;
  localparam logic [1:0] ERR_RANGE    = 2'd3;

  localparam logic [17:0] BOARD_EMPTY = 18'h2AAAA;
  localparam logic [3:0]  LAST_IDX    = 4'(CELL_COUNT - 1);
  localparam logic [3:0]  FULL_COUNT  = 4'(CELL_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Callers guarantee idx <= LAST_IDX before trusting the returned code.
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
    logic [17:0] shifted;
    shifted = board >> {idx, 1'b0};
    return shifted[1:0];
  endfunction

  function automatic logic [17:0] cell_write(input logic [17:0] board, input logic [3:0] idx,
                                             input logic [1:0] code);
    logic [17:0] mask;
    logic [17:0] value;
    mask  = 18'h00003 << {idx, 1'b0};
    value = {16'h0000, code} << {idx, 1'b0};
    return (board & ~mask) | value;
  endfunction

endpackage

// File: rtl/game_board_ctrl_move_check.sv
// Combinational legality check for a move request; reports the highest
// priority error (range, then turn, then occupancy).
module game_move_check
  import game_board_ctrl_pkg::*;
(
  input  logic [17:0] board_flat,
  input  logic [3:0]  move_idx,
  input  logic        move_player,
  input  logic        turn,
  output logic [1:0]  move_err
);

  // Priority-ordered error selection.
  always_comb begin
    move_err = ERR_OK;
    if (move_idx > LAST_IDX) begin
      move_err = ERR_RANGE;
    end else if (move_player != turn) begin
      move_err = ERR_TURN;
    end else if (cell_at(board_flat, move_idx) != CELL_EMPTY) begin
      move_err = ERR_OCCUPIED;
    end else begin
      move_err = ERR_OK;
    end
  end

endmodule

// File: rtl/game_board_ctrl.sv
// Tic-tac-toe board controller: accepts moves over a valid/ready handshake,
// keeps the board, and samples an external win checker after each legal move.
module game_board_ctrl
  import game_board_ctrl_pkg::*;
#(
  parameter int CHECK_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        move_valid,
  output logic        move_ready,
  input  logic [3:0]  move_idx,
  input  logic        move_player,
  output logic        move_ack,
  output logic [1:0]  move_err,
  output logic [17:0] board_flat,
  input  logic [2:0]  who_won,
  output logic        turn,
  output logic [3:0]  move_count,
  output logic        game_over,
  output logic [2:0]  result
);

  localparam int CNT_W = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHECK_LAT - 1);

  state_t           state_r, state_s;
  logic [17:0]      board_r, board_s;
  logic             turn_r, turn_s;
  logic [3:0]       count_r, count_s;
  logic [2:0]       result_r, result_s;
  logic             over_r, over_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             ack_r, ack_s;
  logic [1:0]       err_r, err_s;
  logic [1:0]       chk_err_s;

  game_move_check u_move_check (
    .board_flat  (board_r),
    .move_idx    (move_idx),
    .move_player (move_player),
    .turn        (turn_r),
    .move_err    (chk_err_s)
  );

  assign move_ready = (state_r == ST_IDLE) && !new_game;
  assign move_ack   = ack_r;
  assign move_err   = err_r;
  assign board_flat = board_r;
  assign turn       = turn_r;
  assign move_count = count_r;
  assign game_over  = over_r;
  assign result     = result_r;

  // Next-state and next-output logic; new_game overrides every state.
  always_comb begin
    state_s  = state_r;
    board_s  = board_r;
    turn_s   = turn_r;
    count_s  = count_r;
    result_s = result_r;
    over_s   = over_r;
    cnt_s    = cnt_r;
    ack_s    = 1'b0;
    err_s    = ERR_OK;
    if (new_game) begin
      state_s  = ST_IDLE;
      board_s  = BOARD_EMPTY;
      turn_s   = 1'b0;
      count_s  = 4'd0;
      result_s = RES_NONE;
      over_s   = 1'b0;
      cnt_s    = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (move_valid) begin
            ack_s = 1'b1;
            err_s = chk_err_s;
            if (chk_err_s == ERR_OK) begin
              board_s = cell_write(board_r, move_idx, move_player ? CELL_P2 : CELL_P1);
              turn_s  = ~turn_r;
              count_s = count_r + 4'd1;
              cnt_s   = CNT_LOAD;
              state_s = ST_CHECK;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CHECK: begin
          // The last CHECK cycle is the one where the counter has run out.
          if (cnt_r == CNT_ZERO) begin
            case (who_won)
              RES_P1, RES_P2: begin
                result_s = who_won;
                over_s   = 1'b1;
                state_s  = ST_OVER;
              end
              RES_DRAW: begin
                result_s = RES_DRAW;
                over_s   = 1'b1;
                state_s  = ST_OVER;
              end
              default: begin
                if (count_r == FULL_COUNT) begin
                  result_s = RES_DRAW;
                  over_s   = 1'b1;
                  state_s  = ST_OVER;
                end else begin
                  state_s = ST_IDLE;
                end
              end
            endcase
          end else begin
            cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_OVER: begin
          state_s = ST_OVER;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      board_r  <= BOARD_EMPTY;
      turn_r   <= 1'b0;
      count_r  <= 4'd0;
      result_r <= RES_NONE;
      over_r   <= 1'b0;
      cnt_r    <= CNT_ZERO;
      ack_r    <= 1'b0;
      err_r    <= ERR_OK;
    end else begin
      state_r  <= state_s;
      board_r  <= board_s;
      turn_r   <= turn_s;
      count_r  <= count_s;
      result_r <= result_s;
      over_r   <= over_s;
      cnt_r    <= cnt_s;
      ack_r    <= ack_s;
      err_r    <= err_s;
    end
  end

endmodule

// File: tb/tb_game_board_ctrl.sv
// Scoreboard bench for game_board_ctrl: a game-level model predicts each ack,
// a monitor compares acks, and a behavioural win checker drives who_won.
module tb_game_board_ctrl;

  localparam int CHECK_LAT = 2;

  typedef struct {
    logic [1:0]  err;
    logic [17:0] board;
    logic        turn;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic        move_ready;
  logic [3:0]  move_idx = 4'd0;
  logic        move_player = 1'b0;
  logic        move_ack;
  logic [1:0]  move_err;
  logic [17:0] board_flat;
  logic [2:0]  who_won = 3'd3;
  logic        turn;
  logic [3:0]  move_count;
  logic        game_over;
  logic [2:0]  result;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   force_ww = -1;

  int   m_cell[9];
  logic m_turn;
  int   m_count;
  bit   m_over;
  int   m_result;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  game_board_ctrl #(.CHECK_LAT(CHECK_LAT)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
    .move_ready(move_ready), .move_idx(move_idx), .move_player(move_player),
    .move_ack(move_ack), .move_err(move_err), .board_flat(board_flat),
    .who_won(who_won), .turn(turn), .move_count(move_count),
    .game_over(game_over), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] model_board();
    logic [17:0] b;
    for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_cell[k]);
    return b;
  endfunction

  function automatic bit model_line(input int p);
    for (int l = 0; l < 8; l++)
      if (m_cell[lines[l][0]] == p && m_cell[lines[l][1]] == p && m_cell[lines[l][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 9; k++) m_cell[k] = 2;
    m_turn = 1'b0;
    m_count = 0;
    m_over = 1'b0;
    m_result = 3;
  endtask

  // Behavioural win checker with one register of latency; "not over" is
  // randomly reported as any of 3..7.
  function automatic logic [2:0] checker_eval(input logic [17:0] b);
    int  c[9];
    bit  full;
    full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      c[k] = int'(b[2*k +: 2]);
      if (c[k] == 2) full = 1'b0;
    end
    for (int p = 0; p < 2; p++)
      for (int l = 0; l < 8; l++)
        if (c[lines[l][0]] == p && c[lines[l][1]] == p && c[lines[l][2]] == p)
          return 3'(p);
    if (full && $urandom_range(0, 1) == 0) return 3'd2;
    return 3'($urandom_range(3, 7));
  endfunction

  always @(posedge clk)
    who_won <= (force_ww >= 0) ? 3'(force_ww) : checker_eval(board_flat);

  // Scoreboard monitor: every ack must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && move_ack) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", move_ack, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("ack_err", move_err, e.err);
        check("ack_board", board_flat, e.board);
        check("ack_turn", turn, e.turn);
        check("ack_count", move_count, e.cnt);
      end
    end
  end

  task automatic do_move(input logic p, input logic [3:0] idx, input bit wait_check);
    logic [1:0] err;
    @(negedge clk);
    check("ready_before_move", move_ready, 1'b1);
    if (idx > 4'd8) err = 2'd3;
    else if (p != m_turn) err = 2'd2;
    else if (m_cell[idx] != 2) err = 2'd1;
    else err = 2'd0;
    if (err == 2'd0) begin
      m_cell[idx] = int'(p);
      m_turn = ~m_turn;
      m_count++;
    end
    exp_q.push_back('{err, model_board(), m_turn, 4'(m_count)});
    move_valid = 1'b1;
    move_player = p;
    move_idx = idx;
    @(posedge clk);
    #1 move_valid = 1'b0;
    if (err == 2'd0 && wait_check) begin
      @(negedge clk);
      check("ready_in_check", move_ready, 1'b0);
      repeat (CHECK_LAT) @(posedge clk);
      @(negedge clk);
      if (model_line(int'(p))) begin
        m_over = 1'b1;
        m_result = int'(p);
      end else if (m_count == 9) begin
        m_over = 1'b1;
        m_result = 2;
      end
      check("game_over", game_over, m_over);
      check("result", result, m_result);
      check("ready_after_check", move_ready, !m_over);
    end
  endtask

  task automatic start_game(input bit with_move);
    @(negedge clk);
    new_game = 1'b1;
    move_valid = with_move;
    move_player = 1'b0;
    move_idx = 4'($urandom_range(0, 8));
    #1 check("ready_during_new_game", move_ready, 1'b0);
    @(posedge clk);
    #1 new_game = 1'b0;
    move_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("ng_board", board_flat, model_board());
    check("ng_turn", turn, 1'b0);
    check("ng_count", move_count, 4'd0);
    check("ng_over", game_over, 1'b0);
    check("ng_result", result, 3'd3);
    check("ng_ready", move_ready, 1'b1);
  endtask

  task automatic poke_over();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      move_valid = 1'b1;
      move_player = m_turn;
      move_idx = 4'($urandom_range(0, 8));
    end
    @(negedge clk);
    move_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("over_board_held", board_flat, model_board());
    check("over_held", game_over, 1'b1);
    check("over_result_held", result, m_result);
    check("over_not_ready", move_ready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p1_seq[5];
    int draw_seq[9];
    int tries;
    int r;
    logic p;
    logic [3:0] idx;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_board", board_flat, 18'h2AAAA);
    check("rst_turn", turn, 1'b0);
    check("rst_count", move_count, 4'd0);
    check("rst_result", result, 3'd3);
    check("rst_over", game_over, 1'b0);
    check("rst_ack", move_ack, 1'b0);
    check("rst_err", move_err, 2'd0);
    rst = 1'b0;

    do_move(1'b0, 4'd4, 1'b1);
    do_move(1'b0, 4'd0, 1'b1);
    do_move(1'b1, 4'd4, 1'b1);
    do_move(1'b1, 4'd9, 1'b1);

    start_game(1'b0);
    p1_seq = '{0, 3, 1, 5, 2};
    for (int i = 0; i < 5; i++) do_move(logic'(i % 2), 4'(p1_seq[i]), 1'b1);
    poke_over();

    start_game(1'b0);
    force_ww = 3;
    draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    for (int i = 0; i < 9; i++) do_move(logic'(i % 2), 4'(draw_seq[i]), 1'b1);
    force_ww = -1;
    poke_over();

    start_game(1'b1);

    force_ww = 0;
    do_move(1'b0, 4'd0, 1'b0);
    start_game(1'b0);
    repeat (CHECK_LAT + 2) @(negedge clk);
    check("abort_check_over", game_over, 1'b0);
    check("abort_check_ready", move_ready, 1'b1);
    force_ww = -1;

    do_move(1'b0, 4'd4, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_board", board_flat, 18'h2AAAA);
    check("midrst_turn", turn, 1'b0);
    check("midrst_count", move_count, 4'd0);
    check("midrst_result", result, 3'd3);
    check("midrst_over", game_over, 1'b0);
    check("midrst_ack", move_ack, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_move(1'b0, 4'd8, 1'b1);

    for (int g = 0; g < 30; g++) begin
      start_game(g % 5 == 0);
      tries = 0;
      while (!m_over && tries < 60) begin
        r = $urandom_range(0, 99);
        if (r < 10) begin
          p = m_turn;
          idx = 4'($urandom_range(9, 15));
        end else if (r < 25) begin
          p = ~m_turn;
          idx = 4'($urandom_range(0, 8));
        end else begin
          p = m_turn;
          idx = 4'($urandom_range(0, 8));
        end
        do_move(p, idx, 1'b1);
        tries++;
      end
      if (m_over) poke_over();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_board_ctrl.md
GAME_BOARD_CTRL -- requirements
Module: game_board_ctrl

Interface
REQ-001 Parameter CHECK_LAT, default 2: cycles between a board write and sampling of the win-checker result (covers its registered output).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 new_game  input  1  single-cycle pulse; restart game.
REQ-005 move_valid  input  1  move request present.
REQ-006 move_ready  output  1  block can accept a move this cycle.
REQ-007 move_idx  input  4  target cell, row*3+col (legal 0..8).
REQ-008 move_player  input  1  requesting player (0 = p1, 1 = p2/AI).
REQ-009 move_ack  output  1  one-cycle pulse, request outcome available.
REQ-010 move_err  output  2  outcome code: 0 ok, 1 cell occupied, 2 wrong turn, 3 index out of range.
REQ-011 board_flat  output  18  cell k at bits [2k+1:2k]; 0 = p1, 1 = p2, 2 = empty; drives win-checker board input.
REQ-012 who_won  input  3  win-checker result: 0 p1, 1 p2, 2 draw, 3 not over.
REQ-013 turn  output  1  player whose move is expected next.
REQ-014 move_count  output  4  accepted moves this game, 0..9.
REQ-015 game_over  output  1  game finished.
REQ-016 result  output  3  final result, same encoding as who_won; 3 while game running.

Function
REQ-017 FSM states: IDLE (accepting moves), CHECK (waiting on checker), OVER (finished).
REQ-018 move_ready is 1 only in IDLE with new_game low.
REQ-019 Handshake: move taken when move_valid and move_ready high on the same edge; move_ack pulses exactly one cycle later, move_err valid alongside it.
REQ-020 Error priority: out of range (3), then wrong turn (2), then occupied (1); any error leaves board, turn, and move_count unchanged and keeps state IDLE.
REQ-021 Legal move: cell written with move_player code on the accept edge; turn toggled; move_count incremented; enter CHECK.
REQ-022 CHECK lasts exactly CHECK_LAT cycles; who_won sampled on the final CHECK cycle.
REQ-023 Sampled 0 or 1: result = sampled value, game_over = 1, go to OVER.
REQ-024 Sampled 2: result = 2, game_over = 1, go to OVER.
REQ-025 Sampled 3 with move_count < 9: return to IDLE.
REQ-026 Sampled 3 or 4..7 with move_count = 9: forced draw, result = 2, go to OVER.
REQ-027 Sampled 4..7 with move_count < 9: treated as 3.
REQ-028 OVER holds board, result, and game_over until new_game or rst; move_valid is ignored and no ack is issued.
REQ-029 new_game, any state: all cells set to 2, turn = 0, move_count = 0, result = 3, game_over = 0, state IDLE, on the next edge.
REQ-030 new_game and move_valid in the same cycle: new_game wins; move dropped with no ack.
REQ-031 new_game during CHECK: aborts the pending sample.
REQ-032 move_ack may coincide with the first CHECK cycle.

Reset
REQ-033 rst asynchronously forces: all cells 2 (board_flat = 18'b10_1010_1010_1010_1010), turn 0, move_count 0, result 3, game_over 0, move_ack 0, move_err 0, state IDLE.
REQ-034 rst asserted mid-CHECK discards the pending move result; the board is still cleared.

Structure
REQ-035 Shared package holds: cell codes (P1 = 0, P2 = 1, EMPTY = 2), result codes (0..3), move_err codes, FSM state enum, cell count 9.
REQ-036 One combinational sub-module, game_move_check: takes board_flat, move_idx, move_player, turn; returns move_err.

Verification
REQ-037 Reset, then p1 idx 4 -> ack next cycle, err 0, cell 4 = 0, turn 1, move_count 1, back in IDLE after CHECK_LAT cycles.
REQ-038 p1 again while turn = 1 -> err 2. p2 to occupied cell 4 -> err 1. p2 idx 9 -> err 3. In all three cases board_flat is unchanged.
REQ-039 p1 plays 0, 1, 2, interleaved with p2 plays 3, 5, and checker returns 0 -> game_over 1, result 0, move_ready 0, later move_valid gets no ack.
REQ-040 Nine legal moves with no line, checker returns 3 on the last move -> result 2 (forced draw).
REQ-041 new_game and move_valid in the same cycle during IDLE -> no ack, board all-empty, turn 0.
REQ-042 rst asserted mid-CHECK -> outputs immediately at reset values; the next move is accepted normally.
